// File: rtl/demux_pkg.sv
// demux_pkg
// Shared constants and types for the demux_12 1-to-2 stream demultiplexer.
//   NUM_CH     : number of output channels
//   FIFO_DEPTH : entries per channel elastic buffer
//   occ_t      : per-channel occupancy count (0..FIFO_DEPTH)
package demux_pkg;

    localparam int NUM_CH     = 2;
    localparam int FIFO_DEPTH = 2;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'(FIFO_DEPTH);

endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo
// One output channel of demux_12: a 2-entry FIFO with occupancy tracking
// and a delivered-beat counter.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_push      : write i_data (caller guarantees the FIFO is not full)
//   i_data      : beat to write
//   i_ready     : consumer ready; a pop happens on o_valid & i_ready
//   i_clear     : synchronous clear of the beat counter (FIFO untouched)
//   o_data      : head entry
//   o_valid     : FIFO not empty
//   o_full      : FIFO full, decoded from the occupancy register only
//   o_cnt       : beats popped since reset/clear, wrapping
module demux_chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic [CNT_W-1:0] o_cnt
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    occ_t             r_occ;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pop;

    assign o_valid = (r_occ != OCC_EMPTY);
    assign o_full  = (r_occ == OCC_FULL);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_cnt   = r_cnt;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= OCC_EMPTY;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Push and pop together leave occupancy unchanged.
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Clear takes priority over a same-cycle pop increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux_12.sv
// demux_12
// 1-to-2 stream demultiplexer. Each input beat carries a select bit and is
// steered into the elastic buffer of channel 0 or channel 1. The channels
// are independent, so backpressure on one never stalls or reorders the other.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   in_data/in_sel/in_valid        : input beat, destination, valid
//   in_ready                       : selected channel is not full
//   outN_data/outN_valid/outN_ready: channel N output handshake
//   clear                          : synchronous clear of cnt0/cnt1
//   cnt0, cnt1                     : delivered-beat counters (wrapping)
module demux_12
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_push;
    logic              w_accept;

    // Registered full flags only: a same-cycle pop does not open in_ready,
    // which keeps outN_ready off the in_ready timing path.
    assign in_ready  = ~w_full[in_sel];
    assign w_accept  = in_valid & in_ready;
    assign w_push[0] = w_accept & ~in_sel;
    assign w_push[1] = w_accept &  in_sel;

    demux_chan_fifo #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_chan0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push[0]),
        .i_data  (in_data),
        .i_ready (out0_ready),
        .i_clear (clear),
        .o_data  (out0_data),
        .o_valid (out0_valid),
        .o_full  (w_full[0]),
        .o_cnt   (cnt0)
    );

    demux_chan_fifo #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_chan1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push[1]),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .i_clear (clear),
        .o_data  (out1_data),
        .o_valid (out1_valid),
        .o_full  (w_full[1]),
        .o_cnt   (cnt1)
    );

endmodule

// File: tb/tb_demux_12.sv
// tb_demux_12
// Directed and randomised bench for demux_12 (WIDTH=1, CNT_W=4).
module tb_demux_12;

    logic       clk;
    logic       rst_n;
    logic [0:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [0:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [0:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic       clear;
    logic [3:0] cnt0;
    logic [3:0] cnt1;

    int n_pass;
    int n_total;

    demux_12 #(
        .WIDTH (1),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .clear      (clear),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0; clear = 1'b0;
        tick(); tick();
        n_total++; if (out0_valid !== 1'b0) $display("FAIL reset_out0_valid got=%b exp=0", out0_valid); else n_pass++;
        n_total++; if (out1_valid !== 1'b0) $display("FAIL reset_out1_valid got=%b exp=0", out1_valid); else n_pass++;
        n_total++; if (out0_data !== 1'b0) $display("FAIL reset_out0_data got=%b exp=0", out0_data); else n_pass++;
        n_total++; if (out1_data !== 1'b0) $display("FAIL reset_out1_data got=%b exp=0", out1_data); else n_pass++;
        n_total++; if (cnt0 !== 4'd0) $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); else n_pass++;
        n_total++; if (cnt1 !== 4'd0) $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        in_sel = 1'b1; in_data = 1'b1; in_valid = 1'b1; out1_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got=%b exp=1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        #1;
        n_total++; if (out1_valid !== 1'b1) $display("FAIL single_out1_valid got=%b exp=1", out1_valid); else n_pass++;
        n_total++; if (out1_data !== 1'b1) $display("FAIL single_out1_data got=%b exp=1", out1_data); else n_pass++;
        n_total++; if (out0_valid !== 1'b0) $display("FAIL single_out0_valid got=%b exp=0", out0_valid); else n_pass++;
        tick();
        n_total++; if (out1_valid !== 1'b0) $display("FAIL single_out1_drop got=%b exp=0", out1_valid); else n_pass++;
        n_total++; if (cnt1 !== 4'd1) $display("FAIL single_cnt1 got=%0d exp=1", cnt1); else n_pass++;
        n_total++; if (out0_valid !== 1'b0) $display("FAIL single_out0_stays got=%b exp=0", out0_valid); else n_pass++;
        out1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_sel = 1'b0; in_valid = 1'b1; in_data = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_accept1 got=%b exp=1", in_ready); else n_pass++;
        tick();
        in_data = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_accept2 got=%b exp=1", in_ready); else n_pass++;
        tick();
        in_data = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (out0_data !== 1'b1) $display("FAIL bp_head got=%b exp=1", out0_data); else n_pass++;
        in_sel = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_switch_sel got=%b exp=1", in_ready); else n_pass++;
        in_sel = 1'b0; out0_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_no_comb_ready got=%b exp=0", in_ready); else n_pass++;
        tick();
        n_total++; if (out0_data !== 1'b0) $display("FAIL bp_order2 got=%b exp=0", out0_data); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_recover got=%b exp=1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        #1;
        n_total++; if (out0_valid !== 1'b1) $display("FAIL bp_third_valid got=%b exp=1", out0_valid); else n_pass++;
        n_total++; if (out0_data !== 1'b1) $display("FAIL bp_third_data got=%b exp=1", out0_data); else n_pass++;
        tick();
        n_total++; if (out0_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", out0_valid); else n_pass++;
        n_total++; if (cnt0 !== 4'd3) $display("FAIL bp_cnt0 got=%0d exp=3", cnt0); else n_pass++;
        out0_ready = 1'b0;
    endtask

    task automatic test_simul();
        logic [0:0] prev;
        in_sel = 1'b0; in_valid = 1'b1; in_data = 1'b1; out0_ready = 1'b0;
        tick();
        prev = 1'b1;
        out0_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = (i % 2 == 1) ? 1'b1 : 1'b0;
            #1;
            n_total++; if (out0_valid !== 1'b1 || out0_data !== prev)
                $display("FAIL simul_head_%0d got=%b/%b exp=1/%b", i, out0_valid, out0_data, prev); else n_pass++;
            tick();
            prev = in_data;
        end
        in_valid = 1'b0;
        #1;
        n_total++; if (out0_valid !== 1'b1) $display("FAIL simul_occ1 got=%b exp=1", out0_valid); else n_pass++;
        n_total++; if (out0_data !== 1'b1) $display("FAIL simul_last got=%b exp=1", out0_data); else n_pass++;
        n_total++; if (cnt0 !== 4'd13) $display("FAIL simul_cnt0 got=%0d exp=13", cnt0); else n_pass++;
        tick();
        n_total++; if (out0_valid !== 1'b0) $display("FAIL simul_drain got=%b exp=0", out0_valid); else n_pass++;
        n_total++; if (cnt0 !== 4'd14) $display("FAIL simul_cnt0_final got=%0d exp=14", cnt0); else n_pass++;
        out0_ready = 1'b0;
    endtask

    task automatic test_wrap();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_total++; if (cnt0 !== 4'd0) $display("FAIL wrap_clear_cnt0 got=%0d exp=0", cnt0); else n_pass++;
        n_total++; if (cnt1 !== 4'd0) $display("FAIL wrap_clear_cnt1 got=%0d exp=0", cnt1); else n_pass++;
        in_sel = 1'b1; in_valid = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = (i % 2 == 1) ? 1'b1 : 1'b0;
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL wrap_throughput_%0d got=%b exp=1", i, in_ready); else n_pass++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (cnt1 !== 4'd1) $display("FAIL wrap_cnt1 got=%0d exp=1", cnt1); else n_pass++;
        n_total++; if (out1_valid !== 1'b0) $display("FAIL wrap_empty got=%b exp=0", out1_valid); else n_pass++;
        out1_ready = 1'b0; in_valid = 1'b1; in_data = 1'b1;
        tick();
        in_valid = 1'b0; out1_ready = 1'b1; clear = 1'b1;
        #1;
        n_total++; if (out1_valid !== 1'b1) $display("FAIL wrap_pre_pop got=%b exp=1", out1_valid); else n_pass++;
        tick();
        clear = 1'b0;
        n_total++; if (cnt1 !== 4'd0) $display("FAIL wrap_clear_wins got=%0d exp=0", cnt1); else n_pass++;
        n_total++; if (out1_valid !== 1'b0) $display("FAIL wrap_popped got=%b exp=0", out1_valid); else n_pass++;
        out1_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1; in_data = 1'b1;
        in_sel = 1'b0;
        tick(); tick();
        in_sel = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rstmid_full1 got=%b exp=0", in_ready); else n_pass++;
        in_sel = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rstmid_full0 got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1)
            $display("FAIL rstmid_pre_valid got=%b%b exp=11", out0_valid, out1_valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (out0_valid !== 1'b0) $display("FAIL rstmid_async_out0 got=%b exp=0", out0_valid); else n_pass++;
        n_total++; if (out1_valid !== 1'b0) $display("FAIL rstmid_async_out1 got=%b exp=0", out1_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_async_ready got=%b exp=1", in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_total++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0)
            $display("FAIL rstmid_no_stale got=%b%b exp=00", out0_valid, out1_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready0 got=%b exp=1", in_ready); else n_pass++;
        in_sel = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready1 got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_random();
        logic [0:0] q0[$];
        logic [0:0] q1[$];
        logic       exp_rdy;
        int         pops0;
        int         pops1;
        int         sum_cnt;
        pops0 = 0; pops1 = 0;
        for (int c = 0; c < 1000; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = 1'($urandom_range(0, 1));
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = in_sel ? (q1.size() < 2) : (q0.size() < 2);
            n_total++; if (in_ready !== exp_rdy) $display("FAIL rand_in_ready_%0d got=%b exp=%b", c, in_ready, exp_rdy); else n_pass++;
            n_total++; if (out0_valid !== (q0.size() != 0)) $display("FAIL rand_out0_valid_%0d got=%b exp=%0d", c, out0_valid, q0.size() != 0); else n_pass++;
            n_total++; if (out1_valid !== (q1.size() != 0)) $display("FAIL rand_out1_valid_%0d got=%b exp=%0d", c, out1_valid, q1.size() != 0); else n_pass++;
            if (q0.size() != 0) begin
                n_total++; if (out0_data !== q0[0]) $display("FAIL rand_out0_data_%0d got=%b exp=%b", c, out0_data, q0[0]); else n_pass++;
                if (out0_ready) begin
                    void'(q0.pop_front());
                    pops0++;
                end
            end
            if (q1.size() != 0) begin
                n_total++; if (out1_data !== q1[0]) $display("FAIL rand_out1_data_%0d got=%b exp=%b", c, out1_data, q1[0]); else n_pass++;
                if (out1_ready) begin
                    void'(q1.pop_front());
                    pops1++;
                end
            end
            if (in_valid && exp_rdy) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
            tick();
        end
        in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        #1;
        n_total++; if (cnt0 !== 4'(pops0 % 16)) $display("FAIL rand_cnt0 got=%0d exp=%0d", cnt0, pops0 % 16); else n_pass++;
        n_total++; if (cnt1 !== 4'(pops1 % 16)) $display("FAIL rand_cnt1 got=%0d exp=%0d", cnt1, pops1 % 16); else n_pass++;
        sum_cnt = int'(cnt0) + int'(cnt1);
        n_total++; if ((sum_cnt % 16) != ((pops0 + pops1) % 16))
            $display("FAIL rand_cnt_sum got=%0d exp=%0d", sum_cnt % 16, (pops0 + pops1) % 16); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_simul();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
